signed_addsub_pipe: RTL and testbench
=====================================

Name: signed_addsub_pipe

Overview:
- Parametrised, two-stage pipelined signed add/subtract unit with a carry-lookahead datapath.
- Successor to the fixed 8-bit combinational signed adder.
- Adds runtime add/sub mode, carry and overflow flags, and a valid/ready handshake with backpressure.
- Sits in the adders library as the arithmetic core for streaming DSP and accumulator blocks.

Parameters:
- WIDTH, 8: operand/result width in bits; even, minimum 4.
- GROUP, 4: CLA group size in bits; must divide WIDTH/2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  signed operand A, two's complement.
- b  input  WIDTH  signed operand B, two's complement.
- sub  input  1  0: s=a+b; 1: s=a-b.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- s  output  WIDTH  result, low WIDTH bits.
- carry  output  1  carry out of the MSB, unsigned view.
- overflow  output  1  signed overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: out_valid=0, s=0, carry=0, overflow=0, and all internal stage valids 0. in_ready=1 in the cycle after reset.
- Reset mid-operation: any beats in flight are discarded, not emitted.
- Operand transform: b_eff = sub ? ~b : b; cin = sub.
- Stage 1: registers a, b_eff, sub and the low-half sum/carry (bits WIDTH/2-1..0) computed by GROUP-bit CLA blocks.
- Stage 2: computes the high half with the registered carry and registers s, carry and overflow.
- Overflow: (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]).
- Carry: raw carry out of bit WIDTH-1 (for sub, 1 means no borrow).
- Latency: accepted beat appears on out_valid exactly 2 cycles later when there is no backpressure.
- Throughput: 1 beat/cycle.
- Handshake:
  - adv2 = !v2 || out_ready; in_ready = !v1 || adv2.
  - Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
  - Stage 1 loads on input transfer. Otherwise, if adv2, v1 clears.
  - Stage 2 loads from stage 1 when adv2.
- Stall: while out_valid=1 and out_ready=0, s/carry/overflow and out_valid hold stable. A beat in stage 1 is retained. in_ready=0 once both stages are full.
- Simultaneous accept and emit on a full pipe: the pipe shifts with no bubble and no loss.
- Ordering: results strictly in input order. No beat is duplicated or dropped.
- in_ready is combinational from out_ready only; no path from in_valid.
- Width rules: no internal bit growth beyond WIDTH+1. The most negative value is handled by plain two's complement, e.g. 0 - 0x80 = 0x80 with overflow=1.

Optional Feature:
- Macro: SIGNED_ADDSUB_SATURATE_EN.
- Defined: on overflow, s clamps to the signed limit in the direction of the true result:
  - 0x7F..F when a[MSB]=0.
  - 0x80..0 when a[MSB]=1.
  - overflow is still reported as 1; carry is unchanged (raw). Saturation is applied in stage 2; latency is unchanged.
- Undefined: s is the wrapped result, and the clamp logic is absent from the netlist.

Test Plan:
- WIDTH=8 add, streamed back-to-back with out_ready=1:
  - (0x00,0x70) -> s=0x70, ovf=0
  - (0x70,0x70) -> s=0xE0, ovf=1
  - (0x70,0x90) -> s=0x00, carry=1, ovf=0
  - (0x90,0x90) -> s=0x20, carry=1, ovf=1
  - (0x90,0xFF) -> s=0x8F, ovf=0
  - Each result appears 2 cycles after issue, one per cycle, in order.
- Subtract: (0x80,0x01,sub=1) -> s=0x7F, ovf=1. (0x05,0x05,sub=1) -> s=0x00, carry=1, ovf=0. (0x00,0x80,sub=1) -> s=0x80, ovf=1.
- Backpressure: issue 4 beats, hold out_ready=0 for 5 cycles.
  - Expect in_ready=0 after 2 beats are accepted.
  - First result held stable.
  - On release, all 4 results emerge in order with none lost.
- Reset mid-stream: assert rst_n=0 for 1 cycle with both stages full -> next cycle out_valid=0, s=0. No stale beat ever appears afterwards.
- SIGNED_ADDSUB_SATURATE_EN defined: (0x70,0x70) -> s=0x7F, ovf=1. (0x90,0x90) -> s=0x80, ovf=1. (0x90,0xFF) -> s=0x8F, ovf=0.
- WIDTH=16, GROUP=4: (0x7FFF,0x0001) -> s=0x8000, ovf=1. Then 1000 random beats with random out_ready are checked against a behavioural model.

Source files
------------

// File: rtl/signed_addsub_pipe.sv
// Two-stage pipelined signed add/subtract with group carry-lookahead and valid/ready flow control.
// Optional output saturation on signed overflow: define SIGNED_ADDSUB_SATURATE_EN.
module signed_addsub_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned GSZ  = GROUP;
  localparam int unsigned NGRP = HALF / GSZ;

  // Returns {carry_out, sum}; carries inside each group are flattened generate/propagate products.
  function automatic logic [HALF:0] cla_half(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            cin);
    logic [HALF-1:0] g;
    logic [HALF-1:0] p;
    logic [HALF:0]   c;
    logic            term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int unsigned k = 0; k < NGRP; k++) begin
      for (int unsigned i = 0; i < GSZ; i++) begin
        term = c[k*GSZ];
        for (int unsigned m = 0; m <= i; m++) term = term & p[k*GSZ+m];
        c[k*GSZ+i+1] = term;
        for (int unsigned j = 0; j <= i; j++) begin
          term = g[k*GSZ+j];
          for (int unsigned m = j + 1; m <= i; m++) term = term & p[k*GSZ+m];
          c[k*GSZ+i+1] = c[k*GSZ+i+1] | term;
        end
      end
    end
    return {c[HALF], p ^ c[HALF-1:0]};
  endfunction

  logic             v1;
  logic [HALF-1:0]  a_hi1;
  logic [HALF-1:0]  b_hi1;
  logic [HALF-1:0]  lo1;
  logic             c1;
  logic             adv2;
  logic             take;
  logic [WIDTH-1:0] b_eff;
  logic [HALF:0]    lo_sum;
  logic [HALF:0]    hi_sum;
  logic [WIDTH-1:0] s_raw;
  logic [WIDTH-1:0] s_next;
  logic             ovf_next;

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !v1 || adv2;
  assign take     = in_valid && in_ready;

  always_comb begin
    b_eff    = sub ? ~b : b;
    lo_sum   = cla_half(a[HALF-1:0], b_eff[HALF-1:0], sub);
    hi_sum   = cla_half(a_hi1, b_hi1, c1);
    s_raw    = {hi_sum[HALF-1:0], lo1};
    ovf_next = (a_hi1[HALF-1] == b_hi1[HALF-1]) && (s_raw[WIDTH-1] != a_hi1[HALF-1]);
`ifdef SIGNED_ADDSUB_SATURATE_EN
    s_next   = ovf_next ? {a_hi1[HALF-1], {(WIDTH-1){~a_hi1[HALF-1]}}} : s_raw;
`else
    s_next   = s_raw;
`endif
  end

  // Only the operand high halves are kept: the low half and cin are already folded into lo1/c1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      a_hi1     <= '0;
      b_hi1     <= '0;
      lo1       <= '0;
      c1        <= 1'b0;
      out_valid <= 1'b0;
      s         <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (take) begin
        v1    <= 1'b1;
        a_hi1 <= a[WIDTH-1:HALF];
        b_hi1 <= b_eff[WIDTH-1:HALF];
        lo1   <= lo_sum[HALF-1:0];
        c1    <= lo_sum[HALF];
      end else if (adv2) begin
        v1 <= 1'b0;
      end
      if (adv2) begin
        out_valid <= v1;
        if (v1) begin
          s        <= s_next;
          carry    <= hi_sum[HALF];
          overflow <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_addsub_pipe.sv
// Bench for signed_addsub_pipe: 8-bit directed vectors, backpressure and reset,
// plus a 16-bit randomized stream, all scored against an arithmetic reference model.
module tb_signed_addsub_pipe;

`ifdef SIGNED_ADDSUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic iv8, ir8, sub8, ov8, or8, c8, o8;
  logic [7:0] a8, b8, s8;
  logic iv16, ir16, sub16, ov16, or16, c16, o16;
  logic [15:0] a16, b16, s16;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pops8 = 0;
  int   pops16 = 0;
  bit   lat8 = 1'b0;
  exp_t q8[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  signed_addsub_pipe #(.WIDTH(8), .GROUP(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .s(s8), .carry(c8), .overflow(o8)
  );

  signed_addsub_pipe #(.WIDTH(16), .GROUP(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .sub(sub16),
    .out_valid(ov16), .out_ready(or16), .s(s16), .carry(c16), .overflow(o16)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Exact-integer reference: true signed result, then wrap or clamp.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic sub, output logic [15:0] s,
                                output logic c, output logic o);
    longint m, ua, ub, ta, tb, t, mx, mn;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    ta = (ua >= m / 2) ? ua - m : ua;
    tb = (ub >= m / 2) ? ub - m : ub;
    t  = sub ? ta - tb : ta + tb;
    mx = m / 2 - 1;
    mn = -(m / 2);
    o  = (t > mx) || (t < mn);
    c  = sub ? (ua >= ub) : (ua + ub >= m);
    s  = 16'(t & (m - 1));
    if (SAT && o) s = (t > mx) ? 16'(mx) : 16'(mn & (m - 1));
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q8.delete();
      q16.delete();
    end else begin
      if (ov8) begin
        if (q8.size() == 0) chk("stale_beat8", 32'(ov8), 32'(0));
        else begin
          e = q8[0];
          chk("s8", 32'(s8), 32'(e.s[7:0]));
          chk("carry8", 32'(c8), 32'(e.c));
          chk("ovf8", 32'(o8), 32'(e.o));
          if (or8) begin
            if (e.lat) chk("latency8", 32'(cyc - e.cyc), 32'(2));
            void'(q8.pop_front());
            pops8++;
          end
        end
      end
      if (iv8 && ir8) begin
        model(8, {8'h00, a8}, {8'h00, b8}, sub8, e.s, e.c, e.o);
        e.cyc = cyc;
        e.lat = lat8;
        q8.push_back(e);
      end
      if (ov16) begin
        if (q16.size() == 0) chk("stale_beat16", 32'(ov16), 32'(0));
        else begin
          e = q16[0];
          chk("s16", 32'(s16), 32'(e.s));
          chk("carry16", 32'(c16), 32'(e.c));
          chk("ovf16", 32'(o16), 32'(e.o));
          if (or16) begin
            void'(q16.pop_front());
            pops16++;
          end
        end
      end
      if (iv16 && ir16) begin
        model(16, a16, b16, sub16, e.s, e.c, e.o);
        e.cyc = cyc;
        e.lat = 1'b0;
        q16.push_back(e);
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int n = 0;
    a8 = a; b8 = b; sub8 = sub; iv8 = 1'b1;
    @(negedge clk);
    while (!ir8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir8) chk("send8_timeout", 32'(ir8), 32'(1));
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic sub, input bit rnd);
    int n = 0;
    a16 = a; b16 = b; sub16 = sub; iv16 = 1'b1;
    forever begin
      @(negedge clk);
      if (ir16) break;
      n++;
      if (n > 200) begin
        chk("send16_timeout", 32'(ir16), 32'(1));
        break;
      end
      @(posedge clk); #1;
      if (rnd) or16 = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    iv16 = 1'b0;
    if (rnd) or16 = 1'($urandom_range(0, 1));
  endtask

  // Pins the model to hand-computed results, then streams the vector.
  task automatic vec8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input logic [7:0] s_wrap, input logic [7:0] s_sat,
                      input logic c, input logic o);
    logic [15:0] ms;
    logic mc, mo;
    model(8, {8'h00, a}, {8'h00, b}, sub, ms, mc, mo);
    chk("model8_s", 32'(ms), SAT ? 32'(s_sat) : 32'(s_wrap));
    chk("model8_c", 32'(mc), 32'(c));
    chk("model8_o", 32'(mo), 32'(o));
    send8(a, b, sub);
  endtask

  task automatic drain(input int exp_pops8, input int exp_pops16);
    int n = 0;
    @(posedge clk); #1;
    or8 = 1'b1;
    or16 = 1'b1;
    while ((q8.size() != 0 || q16.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_q8", 32'(q8.size()), 32'(0));
    chk("drain_q16", 32'(q16.size()), 32'(0));
    chk("pops8", 32'(pops8), 32'(exp_pops8));
    chk("pops16", 32'(pops16), 32'(exp_pops16));
  endtask

  initial begin
    logic [15:0] ms, ra, rb;
    logic mc, mo;
    rst_n = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; or8 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; or16 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid8", 32'(ov8), 32'(0));
    chk("rst_s8", 32'(s8), 32'(0));
    chk("rst_carry8", 32'(c8), 32'(0));
    chk("rst_ovf8", 32'(o8), 32'(0));
    chk("rst_in_ready8", 32'(ir8), 32'(1));
    chk("rst_out_valid16", 32'(ov16), 32'(0));
    @(posedge clk); #1;

    // Back-to-back stream with out_ready high: latency is checked on every result.
    lat8 = 1'b1;
    vec8(8'h00, 8'h70, 1'b0, 8'h70, 8'h70, 1'b0, 1'b0);
    vec8(8'h70, 8'h70, 1'b0, 8'hE0, 8'h7F, 1'b0, 1'b1);
    vec8(8'h70, 8'h90, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    vec8(8'h90, 8'h90, 1'b0, 8'h20, 8'h80, 1'b1, 1'b1);
    vec8(8'h90, 8'hFF, 1'b0, 8'h8F, 8'h8F, 1'b1, 1'b0);
    vec8(8'h80, 8'h01, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1);
    vec8(8'h05, 8'h05, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    vec8(8'h00, 8'h80, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1 lat8 = 1'b0;
    chk("stream_pops8", 32'(pops8), 32'(8));

    // Backpressure: two beats fill the pipe, the rest wait for release.
    or8 = 1'b0;
    send8(8'h11, 8'h22, 1'b0);
    send8(8'h7F, 8'h01, 1'b0);
    a8 = 8'h80; b8 = 8'h80; sub8 = 1'b1; iv8 = 1'b1;
    model(8, 16'h0011, 16'h0022, 1'b0, ms, mc, mo);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(ir8), 32'(0));
      chk("bp_out_valid", 32'(ov8), 32'(1));
      chk("bp_hold_s", 32'(s8), 32'(ms[7:0]));
    end
    @(posedge clk); #1;
    or8 = 1'b1;
    send8(8'h80, 8'h80, 1'b1);
    send8(8'hC3, 8'h3C, 1'b1);
    drain(12, 0);

    // Reset with both stages full: nothing in flight may emerge afterwards.
    or8 = 1'b0;
    send8(8'h40, 8'h40, 1'b0);
    send8(8'h01, 8'h02, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    or8 = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid8", 32'(ov8), 32'(0));
    chk("midrst_s8", 32'(s8), 32'(0));
    chk("midrst_in_ready8", 32'(ir8), 32'(1));
    repeat (6) @(posedge clk);
    #1 chk("midrst_pops8", 32'(pops8), 32'(12));

    // 16-bit: pinned corner, then randomized traffic with random backpressure.
    model(16, 16'h7FFF, 16'h0001, 1'b0, ms, mc, mo);
    chk("model16_s", 32'(ms), SAT ? 32'h7FFF : 32'h8000);
    chk("model16_o", 32'(mo), 32'(1));
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        or16 = 1'($urandom_range(0, 1));
      end
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'h8000;
      if ($urandom_range(0, 7) == 0) rb = 16'h8000;
      if ($urandom_range(0, 7) == 0) rb = 16'h7FFF;
      send16(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
    end
    drain(12, 1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
